// File: rtl/pulse_pacer.sv
// pulse_pacer: rate-limits dense event requests into single-cycle pulses
// spaced at least GAP clk_a cycles apart (start-to-start), so a downstream
// pulse synchronizer never sees a pulse while its handshake is busy.
// Events that arrive faster than they can be issued are held in a
// saturating pending counter; events lost at saturation set a sticky flag.
//
// Interface contract: evt_in is a request with no back-pressure. Every
// clk_a edge at which it is high counts as one event, and it is always
// accepted unless the pending counter is full with no issue on that edge.
// pls_a is a one-cycle strobe with no acknowledge; spacing is the only
// flow control toward the synchronizer.
//
// GAP is expected to lie in 2..255 so that GAP-1 fits the 8-bit gap counter.
module pulse_pacer #(
  parameter int GAP = 24,
  parameter int CW  = 4
) (
  input  logic          clk_a,
  input  logic          rst,
  input  logic          evt_in,
  input  logic          clr_ovf,
  output logic          pls_a,
  output logic [CW-1:0] pend_cnt,
  output logic          busy,
  output logic          ovf
);

  typedef enum logic {
    IDLE     = 1'b0,
    GAP_WAIT = 1'b1
  } state_t;

  localparam logic [CW-1:0] PEND_MAX   = '1;
  localparam logic [7:0]    GAP_RELOAD = 8'(GAP - 1);

  state_t        state;
  state_t        state_nxt;
  logic [7:0]    gap_cnt;
  logic [7:0]    gap_cnt_nxt;
  logic          issue;
  logic          drop;
  logic [CW-1:0] pend_nxt;
  logic          ovf_nxt;

  // Next-state logic: issue from IDLE whenever something is pending, then
  // hold off in GAP_WAIT until GAP edges have elapsed since the issue.
  always_comb begin
    state_nxt   = state;
    gap_cnt_nxt = gap_cnt;
    issue       = 1'b0;
    case (state)
      IDLE: begin
        if (pend_cnt != '0) begin
          issue       = 1'b1;
          state_nxt   = GAP_WAIT;
          gap_cnt_nxt = GAP_RELOAD;
        end
      end
      GAP_WAIT: begin
        if (gap_cnt == 8'd1) begin
          state_nxt   = IDLE;
          gap_cnt_nxt = 8'd0;
        end else begin
          gap_cnt_nxt = gap_cnt - 8'd1;
        end
      end
      default: begin
        state_nxt   = IDLE;
        gap_cnt_nxt = 8'd0;
      end
    endcase
  end

  // Pending counter and overflow flag: an event coinciding with an issue
  // nets to zero, so a full counter only drops when nothing is issued.
  always_comb begin
    pend_nxt = pend_cnt;
    drop     = 1'b0;
    ovf_nxt  = ovf;
    if (issue && !evt_in) begin
      pend_nxt = pend_cnt - 1'b1;
    end else if (!issue && evt_in) begin
      if (pend_cnt == PEND_MAX) begin
        drop = 1'b1;
      end else begin
        pend_nxt = pend_cnt + 1'b1;
      end
    end
    // A drop on the same edge as a clear must leave the flag set.
    if (drop) begin
      ovf_nxt = 1'b1;
    end else if (clr_ovf) begin
      ovf_nxt = 1'b0;
    end
  end

  // State register and gap counter.
  always_ff @(posedge clk_a or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      gap_cnt <= 8'd0;
    end else begin
      state   <= state_nxt;
      gap_cnt <= gap_cnt_nxt;
    end
  end

  // Registered outputs: pulse strobe, pending count and sticky overflow.
  always_ff @(posedge clk_a or posedge rst) begin
    if (rst) begin
      pls_a    <= 1'b0;
      pend_cnt <= '0;
      ovf      <= 1'b0;
    end else begin
      pls_a    <= issue;
      pend_cnt <= pend_nxt;
      ovf      <= ovf_nxt;
    end
  end

  assign busy = (state == GAP_WAIT) | (pend_cnt != '0);

endmodule

// File: doc/pulse_pacer.md
# pulse_pacer

Upstream rate-limiter for the clock-crossing pulse synchronizer, in the source clock domain `clk_a`. The synchronizer silently drops a source pulse that arrives while its level/acknowledge handshake is still busy. This block accepts arbitrarily dense event pulses, counts them as pending, and re-issues them as single-cycle `pls_a` pulses spaced at least `GAP` cycles apart, so every event crosses exactly once. Lost events, when the pending counter saturates, are flagged by a sticky overflow bit.

## Interface
- `GAP`, default 24: minimum `clk_a` cycles between consecutive `pls_a` rising edges (start-to-start). Legal range 2..255.
  - 24 covers the synchronizer's full handshake round trip for `clk_b` frequency ≥ `clk_a`/2.
  - The integrator raises `GAP` for slower `clk_b`.
- `CW`, default 4: pending-counter width. Capacity is 2^CW−1 events.

Ports:
- `clk_a`  in  1  source-domain clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `evt_in`  in  1  event request, sampled every edge; each high cycle is one event.
- `clr_ovf`  in  1  synchronous clear of `ovf`.
- `pls_a`  out  1  registered single-cycle pulse to the synchronizer input.
- `pend_cnt`  out  CW  events accepted but not yet issued.
- `busy`  out  1  `(state==GAP_WAIT) | (pend_cnt!=0)`.
- `ovf`  out  1  sticky: at least one event dropped.

## Operation
- State machine states: `IDLE` and `GAP_WAIT`.
  - In `IDLE`, `pend_cnt!=0` at an edge causes an issue at that edge: `pls_a<=1`, `gap_cnt<=GAP-1`, state to `GAP_WAIT`.
  - In `GAP_WAIT`, `gap_cnt` decrements each edge. The edge at which `gap_cnt==1` moves the state to `IDLE` (`gap_cnt<=0`).
  - `pls_a` is 0 on every non-issue edge. It is never high for two consecutive cycles.
- Pending counter, per edge, with `issue` and `evt_in`:
  - `issue & evt_in`: unchanged.
  - `issue & !evt_in`: −1.
  - `!issue & evt_in & pend_cnt<max`: +1.
  - `!issue & evt_in & pend_cnt==max`: event dropped, count stays at max, `ovf<=1`.
  - An event arriving when full at the same edge as an issue is accepted (net 0), not dropped.
- `gap_cnt` width is 8 bits. Arithmetic never wraps: `pend_cnt` saturates at max and never decrements below 0, since an issue needs `pend_cnt!=0`.
- `ovf` is set by a drop and cleared by `clr_ovf`. If a drop and `clr_ovf` occur at the same edge, `ovf` ends at 1 (set wins).
- `rst` asserted at any time, including mid-gap or with events pending:
  - immediately forces `IDLE`, `gap_cnt=0`, `pend_cnt=0`, `pls_a=0`, `ovf=0`, `busy=0`.
  - Pending events are discarded.
  - After `rst` deasserts, the first edge behaves as from power-up.

## Timing
- Reset values: `pls_a=0`, `pend_cnt=0`, `busy=0`, `ovf=0`, state `IDLE`.
- Latency: `evt_in` sampled at edge k into an idle, empty block gives `pend_cnt=1` after edge k. `pls_a` is high for the cycle after edge k+1, and `pend_cnt` returns to 0 after edge k+1.
- With a backlog, issues occur at edges t, t+GAP, t+2·GAP, …, exactly GAP apart.
- Spacing never falls below GAP, whatever the `evt_in` pattern.
- `busy` deasserts on the edge the state returns to `IDLE` with `pend_cnt==0`, i.e. GAP−1 edges after the last issue.
- All outputs are registered or decoded from registers. There is no combinational path from the inputs.

## Test plan
- **Single event, GAP=24:** `evt_in` high for one cycle at edge 0 → `pend_cnt`=1 after edge 0, `pls_a` high after edge 1 only, `busy` low after edge 24.
- **Burst, GAP=4, CW=4:** `evt_in` high at edges 0, 1, 2 → `pls_a` high after edges 1, 5, 9. `pend_cnt` sequence after edges 0..2 is 1, 1, 2. `ovf`=0.
- **Overflow, GAP=8, CW=2:** `evt_in` high at edges 0..5 → `pend_cnt` reaches 3 at edge 3. Drops occur at edges 4 and 5, and `ovf`=1 from edge 4. Exactly 4 pulses are issued, at edges 1, 9, 17, 25.
- **Set vs clear:** `clr_ovf` and a full-counter drop at the same edge → `ovf` stays 1. `clr_ovf` alone at the next edge → `ovf`=0.
- **Reset mid-gap:** GAP=24, two pending events, `rst` pulsed 5 cycles after the first issue → all outputs are 0 immediately. No further `pls_a` after release until a new `evt_in`.
- **Continuous `evt_in`, CW=4, GAP=2, 40 cycles:** check minimum `pls_a` spacing ≥ 2. Issued count plus dropped count plus final `pend_cnt` must equal 40.
